ast_width_reducer: RTL and testbench
====================================

# ast_width_reducer

Avalon-ST width reducer: accepts wide beats (DATA_IN_W) on a sink port and re-emits each as a sequence of narrow words (DATA_OUT_W) on a source port, with sop/eop/empty/channel rewritten for the narrow bus. It is the counterpart of the width extender and sits on the egress side of the wide datapath, feeding narrow links and sinks. One beat is buffered, and a new beat is accepted in the same cycle its predecessor's last word leaves, so throughput is gap-free.

## Interface
- DATA_IN_W, 256: sink data width, multiple of DATA_OUT_W
- DATA_OUT_W, 64: source data width, multiple of 8
- CHANNEL_W, 10: channel width
- EMPTY_IN_W, $clog2(DATA_IN_W/8): sink empty width
- EMPTY_OUT_W, $clog2(DATA_OUT_W/8), min 1: source empty width
- clk_i  in  1  clock
- srst_n_i  in  1  synchronous reset, active-low
- ast_data_i  in  DATA_IN_W  sink data
- ast_startofpacket_i  in  1  sink sop
- ast_endofpacket_i  in  1  sink eop
- ast_valid_i  in  1  sink valid
- ast_empty_i  in  EMPTY_IN_W  unused bytes in eop beat
- ast_channel_i  in  CHANNEL_W  sink channel
- ast_ready_o  out  1  sink ready
- ast_data_o  out  DATA_OUT_W  source data
- ast_startofpacket_o  out  1  source sop
- ast_endofpacket_o  out  1  source eop
- ast_valid_o  out  1  source valid
- ast_empty_o  out  EMPTY_OUT_W  unused bytes in eop word
- ast_channel_o  out  CHANNEL_W  source channel
- ast_ready_i  in  1  source ready

## Operation
- K = DATA_IN_W/DATA_OUT_W, IB = DATA_IN_W/8, OB = DATA_OUT_W/8.
- Word order: word 0 = ast_data_i[DATA_OUT_W-1:0] sent first; word n = bits [(n+1)*DATA_OUT_W-1 : n*DATA_OUT_W]. Empty bytes occupy the most significant end.
- Words per beat: non-eop beat → K (ast_empty_i ignored); eop beat → N = ceil((IB − ast_empty_i)/OB). ast_empty_i ≥ IB is illegal; behaviour is undefined.
- ast_empty_o = N*OB − (IB − ast_empty_i) on the last word of an eop beat, else 0.
- ast_startofpacket_o = 1 only on word 0 of a beat with sop. ast_endofpacket_o = 1 only on word N−1 of a beat with eop.
- ast_channel_o holds the channel latched with the beat, for every word of that beat.
- FSM IDLE/SEND, word counter idx, and last index L (K−1 or N−1), both latched at accept:
  - IDLE: ast_ready_o=1; ast_valid_i → latch beat, idx=0, go SEND.
  - SEND: ast_valid_o=1; on ast_ready_i: if idx<L then idx++; else (last word) ast_ready_o=1 that cycle; if ast_valid_i, latch the new beat, idx=0, stay SEND; otherwise go IDLE.
- ast_ready_o is combinational: (state==IDLE) | (idx==L & ast_ready_i).
- Reset mid-beat discards the buffered beat and all of its remaining words.

## Timing
- Reset values: ast_valid_o=0, ast_startofpacket_o=0, ast_endofpacket_o=0, ast_empty_o=0, ast_channel_o=0, ast_data_o=0, state IDLE, idx=0. ast_ready_o=1 in the first cycle after reset.
- Latency: a beat accepted at edge t drives its word 0 from t+1.
- Sustained throughput: one word per cycle while ast_ready_i=1; no bubble between beats.
- While ast_valid_o=1 and ast_ready_i=0, all source outputs are held stable.
- ast_ready_i must not depend combinationally on ast_ready_o, so no combinational loop is allowed.

## Configuration
- AST_WR_CHANNEL_EN defined: channel is latched per beat and driven on ast_channel_o as described above.
- AST_WR_CHANNEL_EN undefined: ast_channel_i is ignored, ast_channel_o is tied to 0, and no channel register is synthesised. The ports remain present.

## Test plan
All cases use default parameters (K=4, IB=32, OB=8).
- Single beat, sop=eop=1, empty=0, ast_ready_i=1 → 4 words on consecutive cycles; sop on word 0, eop on word 3, ast_empty_o=0; ast_data_o = 64-bit slices, low slice first.
- Eop beat with empty=13 (19 valid bytes) → 3 words; eop on word 2 with ast_empty_o=5. Repeat with empty=24 → 1 word, eop on word 0, ast_empty_o=0.
- 3-beat packet (sop, –, eop empty=0) with source valid continuous and ast_ready_i=1 → 12 contiguous words with no gap; ast_ready_o pulses on cycles 4 and 8; single sop and single eop.
- ast_ready_i random at 50% over 100 random packets → output stream matches the reference model byte-for-byte; source outputs remain stable whenever stalled.
- Beat on channel 5 followed by a beat on channel 9 → words 0–3 carry channel 5, words 4–7 carry channel 9; with the macro undefined, all words carry channel 0.
- srst_n_i=0 asserted for 1 cycle after word 1 of a 4-word beat → ast_valid_o=0 on the next cycle and words 2–3 never appear; the next beat is accepted normally.

Source files
------------

// File: rtl/ast_width_reducer.sv
// Avalon-ST width reducer: re-emits each DATA_IN_W beat as DATA_OUT_W words, low word first.
// Define AST_WR_CHANNEL_EN to latch and forward ast_channel_i; otherwise ast_channel_o is tied to 0.
module ast_width_reducer #(
   parameter int unsigned DATA_IN_W   = 256,
   parameter int unsigned DATA_OUT_W  = 64,
   parameter int unsigned CHANNEL_W   = 10,
   parameter int unsigned EMPTY_IN_W  = $clog2(DATA_IN_W/8),
   parameter int unsigned EMPTY_OUT_W = ((DATA_OUT_W/8) > 1) ? $clog2(DATA_OUT_W/8) : 1
) (
   input  logic                   clk_i,
   input  logic                   srst_n_i,
   input  logic [DATA_IN_W-1:0]   ast_data_i,
   input  logic                   ast_startofpacket_i,
   input  logic                   ast_endofpacket_i,
   input  logic                   ast_valid_i,
   input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
   input  logic [CHANNEL_W-1:0]   ast_channel_i,
   output logic                   ast_ready_o,
   output logic [DATA_OUT_W-1:0]  ast_data_o,
   output logic                   ast_startofpacket_o,
   output logic                   ast_endofpacket_o,
   output logic                   ast_valid_o,
   output logic [EMPTY_OUT_W-1:0] ast_empty_o,
   output logic [CHANNEL_W-1:0]   ast_channel_o,
   input  logic                   ast_ready_i
);

   localparam int unsigned K      = DATA_IN_W / DATA_OUT_W;
   localparam int unsigned IB     = DATA_IN_W / 8;
   localparam int unsigned OB     = DATA_OUT_W / 8;
   localparam int unsigned IDX_W  = (K > 1) ? $clog2(K) : 1;
   localparam int unsigned BYTE_W = $clog2(IB) + 1;

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t                 state;
   state_t                 state_nxt;

   logic [DATA_IN_W-1:0]   beat_data;
   logic                   beat_sop;
   logic                   beat_eop;
   logic [EMPTY_OUT_W-1:0] beat_empty;
   logic [IDX_W-1:0]       idx;
   logic [IDX_W-1:0]       last_idx;

   logic [BYTE_W-1:0]      valid_bytes;
   logic [BYTE_W-1:0]      word_cnt;
   logic [BYTE_W-1:0]      word_bytes;
   logic [IDX_W-1:0]       acc_last;
   logic [EMPTY_OUT_W-1:0] acc_empty;

   logic                   at_last;
   logic                   sending;
   logic                   accept;
   logic                   advance;

   // Word count and output empty of the incoming beat, resolved before it is latched.
   always_comb begin
      valid_bytes = BYTE_W'(IB) - BYTE_W'(ast_empty_i);
      word_cnt    = (valid_bytes + BYTE_W'(OB - 1)) / BYTE_W'(OB);
      word_bytes  = word_cnt * BYTE_W'(OB);
      if (ast_endofpacket_i) begin
         acc_last  = IDX_W'(word_cnt - BYTE_W'(1));
         acc_empty = EMPTY_OUT_W'(word_bytes - valid_bytes);
      end else begin
         acc_last  = IDX_W'(K - 1);
         acc_empty = '0;
      end
   end

   always_comb begin
      state_nxt   = state;
      ast_ready_o = 1'b0;
      at_last     = (idx == last_idx);
      case (state)
         IDLE: begin
            ast_ready_o = 1'b1;
            if (ast_valid_i) begin
               state_nxt = SEND;
            end
         end
         SEND: begin
            // The last word leaving frees the buffer, so the next beat may load in the same cycle.
            if (ast_ready_i && at_last) begin
               ast_ready_o = 1'b1;
               if (!ast_valid_i) begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign sending = (state == SEND);
   assign accept  = ast_valid_i & ast_ready_o;
   assign advance = sending & ast_ready_i;

   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         state      <= IDLE;
         idx        <= '0;
         last_idx   <= '0;
         beat_data  <= '0;
         beat_sop   <= 1'b0;
         beat_eop   <= 1'b0;
         beat_empty <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            beat_data  <= ast_data_i;
            beat_sop   <= ast_startofpacket_i;
            beat_eop   <= ast_endofpacket_i;
            beat_empty <= acc_empty;
            last_idx   <= acc_last;
            idx        <= '0;
         end else if (advance && !at_last) begin
            idx <= idx + IDX_W'(1);
         end
      end
   end

`ifdef AST_WR_CHANNEL_EN
   logic [CHANNEL_W-1:0] beat_channel;

   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         beat_channel <= '0;
      end else if (accept) begin
         beat_channel <= ast_channel_i;
      end
   end

   assign ast_channel_o = beat_channel;
`else
   logic unused_channel;

   assign unused_channel = ^ast_channel_i;
   assign ast_channel_o  = '0;
`endif

   always_comb begin
      ast_data_o = '0;
      for (int unsigned n = 0; n < K; n++) begin
         if (idx == IDX_W'(n)) begin
            ast_data_o = beat_data[n*DATA_OUT_W +: DATA_OUT_W];
         end
      end
   end

   assign ast_valid_o         = sending;
   assign ast_startofpacket_o = sending & beat_sop & (idx == '0);
   assign ast_endofpacket_o   = sending & beat_eop & at_last;
   assign ast_empty_o         = ast_endofpacket_o ? beat_empty : '0;

endmodule

// File: tb/tb_ast_width_reducer.sv
// Directed bench for ast_width_reducer with a queue-based word model and immediate assertions.
`timescale 1ns/1ps
module tb_ast_width_reducer;

`ifdef AST_WR_CHANNEL_EN
   localparam bit CH_EN = 1'b1;
`else
   localparam bit CH_EN = 1'b0;
`endif

   typedef struct packed {
      logic [255:0] d;
      logic         sop;
      logic         eop;
      logic [4:0]   emp;
      logic [9:0]   ch;
   } beat_t;

   typedef struct packed {
      logic [63:0] d;
      logic        sop;
      logic        eop;
      logic [2:0]  emp;
      logic [9:0]  ch;
   } word_t;

   logic         clk = 1'b0;
   logic         srst_n_i;
   logic [255:0] ast_data_i;
   logic         ast_startofpacket_i;
   logic         ast_endofpacket_i;
   logic         ast_valid_i;
   logic [4:0]   ast_empty_i;
   logic [9:0]   ast_channel_i;
   logic         ast_ready_o;
   logic [63:0]  ast_data_o;
   logic         ast_startofpacket_o;
   logic         ast_endofpacket_o;
   logic         ast_valid_o;
   logic [2:0]   ast_empty_o;
   logic [9:0]   ast_channel_o;
   logic         ast_ready_i;

   ast_width_reducer #(
      .DATA_IN_W (256),
      .DATA_OUT_W(64),
      .CHANNEL_W (10)
   ) dut (
      .clk_i              (clk),
      .srst_n_i           (srst_n_i),
      .ast_data_i         (ast_data_i),
      .ast_startofpacket_i(ast_startofpacket_i),
      .ast_endofpacket_i  (ast_endofpacket_i),
      .ast_valid_i        (ast_valid_i),
      .ast_empty_i        (ast_empty_i),
      .ast_channel_i      (ast_channel_i),
      .ast_ready_o        (ast_ready_o),
      .ast_data_o         (ast_data_o),
      .ast_startofpacket_o(ast_startofpacket_o),
      .ast_endofpacket_o  (ast_endofpacket_o),
      .ast_valid_o        (ast_valid_o),
      .ast_empty_o        (ast_empty_o),
      .ast_channel_o      (ast_channel_o),
      .ast_ready_i        (ast_ready_i)
   );

   always #5 clk = ~clk;

   int     tests = 0;
   int     fails = 0;
   beat_t  in_q[$];
   word_t  exp_q[$];
   logic   rst_req;
   word_t  obs_w;
   word_t  prev_w;
   logic   obs_valid;
   logic   obs_ready;
   logic   prev_hold;
   int     out_cnt;
   int     sop_cnt;
   int     eop_cnt;
   logic [2:0] last_eop_empty;
   logic [9:0] last_ch;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic beat_t mk(input logic [63:0] base, input logic sop, input logic eop,
                                input logic [4:0] emp, input logic [9:0] ch);
      beat_t r;
      r.d   = {base + 64'd3, base + 64'd2, base + 64'd1, base};
      r.sop = sop;
      r.eop = eop;
      r.emp = emp;
      r.ch  = ch;
      return r;
   endfunction

   function automatic void expand(input beat_t b);
      int n;
      n = b.eop ? (32 - int'(b.emp) + 7) / 8 : 4;
      for (int i = 0; i < n; i++) begin
         word_t w;
         w.d   = b.d[i*64 +: 64];
         w.sop = b.sop && (i == 0);
         w.eop = b.eop && (i == n - 1);
         w.emp = w.eop ? 3'(n * 8 - (32 - int'(b.emp))) : 3'd0;
         w.ch  = CH_EN ? b.ch : 10'd0;
         exp_q.push_back(w);
      end
   endfunction

   task automatic step(input logic rdy);
      word_t w;
      @(negedge clk);
      srst_n_i    = ~rst_req;
      ast_ready_i = rdy;
      if (in_q.size() > 0) begin
         ast_valid_i         = 1'b1;
         ast_data_i          = in_q[0].d;
         ast_startofpacket_i = in_q[0].sop;
         ast_endofpacket_i   = in_q[0].eop;
         ast_empty_i         = in_q[0].emp;
         ast_channel_i       = in_q[0].ch;
      end else begin
         ast_valid_i         = 1'b0;
         ast_data_i          = '0;
         ast_startofpacket_i = 1'b0;
         ast_endofpacket_i   = 1'b0;
         ast_empty_i         = '0;
         ast_channel_i       = '0;
      end
      #1;
      obs_w     = {ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o};
      obs_valid = ast_valid_o;
      obs_ready = ast_ready_o;
      if (!srst_n_i) begin
         exp_q.delete();
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("stall_hold", 256'({obs_valid, obs_w}), 256'({1'b1, prev_w}));
         end
         if (obs_valid && rdy) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 256'(exp_q.size()), 256'(1));
            end else begin
               w = exp_q.pop_front();
               chk("word", 256'(obs_w), 256'(w));
               out_cnt++;
               last_ch = obs_w.ch;
               if (obs_w.sop) sop_cnt++;
               if (obs_w.eop) begin
                  eop_cnt++;
                  last_eop_empty = obs_w.emp;
               end
            end
         end
         if (ast_valid_i && obs_ready) begin
            expand(in_q[0]);
            void'(in_q.pop_front());
         end
         prev_hold = obs_valid && !rdy;
         prev_w    = obs_w;
      end
      @(posedge clk);
   endtask

   task automatic drain(input bit rnd, input int max_cyc);
      int c;
      c = 0;
      while ((in_q.size() > 0 || exp_q.size() > 0) && c < max_cyc) begin
         step(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
         c++;
      end
      chk("drain_done", 256'(in_q.size() + exp_q.size()), 256'(0));
      in_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int c0;
      int s0;
      int e0;
      logic [12:0] rdy_rec;
      logic [12:0] val_rec;
      beat_t r;
      int nb;

      srst_n_i = 1'b0; ast_valid_i = 1'b0; ast_ready_i = 1'b0;
      ast_data_i = '0; ast_startofpacket_i = 1'b0; ast_endofpacket_i = 1'b0;
      ast_empty_i = '0; ast_channel_i = '0;
      rst_req = 1'b1; prev_hold = 1'b0; prev_w = '0;
      out_cnt = 0; sop_cnt = 0; eop_cnt = 0; last_eop_empty = '0; last_ch = '0;

      // reset values
      step(1'b0);
      step(1'b0);
      rst_req = 1'b0;
      step(1'b1);
      chk("reset_valid", 256'(obs_valid), 256'(0));
      chk("reset_sop",   256'(obs_w.sop), 256'(0));
      chk("reset_eop",   256'(obs_w.eop), 256'(0));
      chk("reset_empty", 256'(obs_w.emp), 256'(0));
      chk("reset_ch",    256'(obs_w.ch),  256'(0));
      chk("reset_data",  256'(obs_w.d),   256'(0));
      chk("reset_ready", 256'(obs_ready), 256'(1));

      // single full beat, latency and word order
      c0 = out_cnt; s0 = sop_cnt; e0 = eop_cnt;
      in_q.push_back(mk(64'hA000, 1'b1, 1'b1, 5'd0, 10'd3));
      step(1'b1);
      step(1'b1);
      chk("lat_valid", 256'(obs_valid), 256'(1));
      chk("lat_word0", 256'(obs_w.d),   256'(64'hA000));
      chk("lat_sop",   256'(obs_w.sop), 256'(1));
      drain(1'b0, 20);
      chk("t1_words", 256'(out_cnt - c0), 256'(4));
      chk("t1_eops",  256'(eop_cnt - e0), 256'(1));
      chk("t1_empty", 256'(last_eop_empty), 256'(0));

      // partial eop beats
      c0 = out_cnt;
      in_q.push_back(mk(64'hB000, 1'b1, 1'b1, 5'd13, 10'd0));
      drain(1'b0, 20);
      chk("e13_words", 256'(out_cnt - c0), 256'(3));
      chk("e13_empty", 256'(last_eop_empty), 256'(5));
      c0 = out_cnt;
      in_q.push_back(mk(64'hB100, 1'b1, 1'b1, 5'd24, 10'd0));
      drain(1'b0, 20);
      chk("e24_words", 256'(out_cnt - c0), 256'(1));
      chk("e24_empty", 256'(last_eop_empty), 256'(0));

      // 3-beat packet, back-to-back
      c0 = out_cnt; s0 = sop_cnt; e0 = eop_cnt;
      in_q.push_back(mk(64'hC000, 1'b1, 1'b0, 5'd0, 10'd1));
      in_q.push_back(mk(64'hC100, 1'b0, 1'b0, 5'd0, 10'd1));
      in_q.push_back(mk(64'hC200, 1'b0, 1'b1, 5'd0, 10'd1));
      for (int i = 0; i < 13; i++) begin
         step(1'b1);
         rdy_rec[i] = obs_ready;
         val_rec[i] = obs_valid;
      end
      drain(1'b0, 20);
      chk("pkt_ready_pattern", 256'(rdy_rec), 256'(13'h1111));
      chk("pkt_valid_pattern", 256'(val_rec), 256'(13'h1FFE));
      chk("pkt_words", 256'(out_cnt - c0), 256'(12));
      chk("pkt_sops",  256'(sop_cnt - s0), 256'(1));
      chk("pkt_eops",  256'(eop_cnt - e0), 256'(1));

      // random packets with 50% sink backpressure
      s0 = sop_cnt; e0 = eop_cnt;
      for (int p = 0; p < 100; p++) begin
         nb = int'($urandom_range(1, 3));
         for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < 8; k++) r.d[k*32 +: 32] = $urandom;
            r.sop = (b == 0);
            r.eop = (b == nb - 1);
            r.emp = 5'($urandom_range(0, 31));
            r.ch  = 10'($urandom_range(0, 1023));
            in_q.push_back(r);
         end
      end
      drain(1'b1, 10000);
      chk("rnd_sops", 256'(sop_cnt - s0), 256'(100));
      chk("rnd_eops", 256'(eop_cnt - e0), 256'(100));

      // channel per beat
      c0 = out_cnt;
      in_q.push_back(mk(64'hD000, 1'b1, 1'b0, 5'd0, 10'd5));
      in_q.push_back(mk(64'hD100, 1'b0, 1'b1, 5'd0, 10'd9));
      drain(1'b0, 30);
      chk("ch_words", 256'(out_cnt - c0), 256'(8));
      chk("ch_last",  256'(last_ch), 256'(CH_EN ? 10'd9 : 10'd0));

      // reset after word 1 of a beat
      in_q.push_back(mk(64'hE000, 1'b1, 1'b1, 5'd0, 10'd2));
      step(1'b1);
      step(1'b1);
      step(1'b1);
      c0 = out_cnt;
      rst_req = 1'b1;
      step(1'b0);
      rst_req = 1'b0;
      step(1'b1);
      chk("rst_valid", 256'(obs_valid), 256'(0));
      step(1'b1);
      step(1'b1);
      chk("rst_no_words", 256'(out_cnt - c0), 256'(0));
      s0 = sop_cnt;
      in_q.push_back(mk(64'hF000, 1'b1, 1'b1, 5'd0, 10'd4));
      drain(1'b0, 20);
      chk("post_rst_words", 256'(out_cnt - c0), 256'(4));
      chk("post_rst_sop",   256'(sop_cnt - s0), 256'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
